alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith/shift/compare ops and iterative
// shift-add multiply / restoring divide sharing one RUN datapath.
module alu_muldiv #(
    parameter int unsigned LEN = 32,
    parameter int unsigned SHW = $clog2(LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     alu_ctrl,
    input  logic [LEN-1:0] aluop1,
    input  logic [LEN-1:0] aluop2,
    output logic           busy,
    output logic           valid,
    output logic [LEN-1:0] alu_result,
    output logic           zero
);
    localparam int unsigned CW = $clog2(LEN) + 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]     r_state, w_state_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [3:0]     r_op, w_op_nx;
    logic [LEN-1:0] r_hi, w_hi_nx;
    logic [LEN-1:0] r_lo, w_lo_nx;
    logic [LEN-1:0] r_opb, w_opb_nx;
    logic           r_negq, w_negq_nx;
    logic           r_negr, w_negr_nx;
    logic           r_valid, w_valid_nx;
    logic [LEN-1:0] r_res, w_res_nx;
    logic           r_zero;

    logic [LEN-1:0] w_alu;
    logic           w_iter;
    logic           w_is_div;
    logic           w_sgn;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [LEN:0]   w_msum;
    logic [2*LEN-1:0] w_mshift;
    logic [LEN:0]   w_trial;
    logic [LEN-1:0] w_rem;
    logic [LEN-1:0] w_quo;
    logic           w_last;

    // Single-cycle operation results
    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            4'b0000: w_alu = aluop1 + aluop2;
            4'b0001: w_alu = aluop1 - aluop2;
            4'b0010: w_alu = aluop1 & aluop2;
            4'b0011: w_alu = aluop1 | aluop2;
            4'b0100: w_alu = aluop1 ^ aluop2;
            4'b0101: w_alu = {{(LEN-1){1'b0}}, $signed(aluop1) < $signed(aluop2)};
            4'b0110: w_alu = aluop1 << aluop2[SHW-1:0];
            4'b0111: w_alu = aluop1 >> aluop2[SHW-1:0];
            4'b1000: w_alu = LEN'($signed(aluop1) >>> aluop2[SHW-1:0]);
            4'b1001: w_alu = {{(LEN-1){1'b0}}, aluop1 < aluop2};
            default: w_alu = '0;
        endcase
    end

    assign w_iter   = alu_ctrl[3] & (alu_ctrl[2] | alu_ctrl[1]);
    assign w_is_div = alu_ctrl[3] & alu_ctrl[2];
    assign w_sgn    = w_is_div & ~alu_ctrl[0];
    assign w_a_neg  = w_sgn & aluop1[LEN-1];
    assign w_b_neg  = w_sgn & aluop2[LEN-1];

    // One shift-add multiply step: {r_hi, r_lo} holds partial product / multiplier
    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(LEN+1){1'b0}});
    assign w_mshift = {w_msum, r_lo[LEN-1:1]};

    // One restoring-divide step: r_hi is partial remainder, r_lo shifts dividend into quotient
    assign w_trial = {r_hi, r_lo[LEN-1]} - {1'b0, r_opb};
    assign w_rem   = w_trial[LEN] ? {r_hi[LEN-2:0], r_lo[LEN-1]} : w_trial[LEN-1:0];
    assign w_quo   = {r_lo[LEN-2:0], ~w_trial[LEN]};
    assign w_last  = (r_cnt == CW'(LEN - 1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_op_nx    = r_op;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_opb_nx   = r_opb;
        w_negq_nx  = r_negq;
        w_negr_nx  = r_negr;
        w_valid_nx = 1'b0;
        w_res_nx   = r_res;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_iter) begin
                        w_res_nx   = w_alu;
                        w_valid_nx = 1'b1;
                    end else if (w_is_div && (aluop2 == '0)) begin
                        w_res_nx   = alu_ctrl[1] ? aluop1 : '1;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_state_nx = S_RUN;
                        w_cnt_nx   = '0;
                        w_op_nx    = alu_ctrl;
                        w_hi_nx    = '0;
                        w_lo_nx    = w_is_div ? (w_a_neg ? LEN'(-aluop1) : aluop1) : aluop2;
                        w_opb_nx   = w_is_div ? (w_b_neg ? LEN'(-aluop2) : aluop2) : aluop1;
                        w_negq_nx  = w_a_neg ^ w_b_neg;
                        w_negr_nx  = w_a_neg;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nx = r_cnt + CW'(1);
                if (r_op[2]) begin
                    w_hi_nx = w_rem;
                    w_lo_nx = w_quo;
                end else begin
                    w_hi_nx = w_mshift[2*LEN-1:LEN];
                    w_lo_nx = w_mshift[LEN-1:0];
                end
                if (w_last) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b1;
                    case (r_op)
                        4'b1010:          w_res_nx = w_mshift[LEN-1:0];
                        4'b1011:          w_res_nx = w_mshift[2*LEN-1:LEN];
                        4'b1100, 4'b1101: w_res_nx = r_negq ? LEN'(-w_quo) : w_quo;
                        default:          w_res_nx = r_negr ? LEN'(-w_rem) : w_rem;
                    endcase
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_opb   <= w_opb_nx;
            r_negq  <= w_negq_nx;
            r_negr  <= w_negr_nx;
            r_valid <= w_valid_nx;
            r_res   <= w_res_nx;
            r_zero  <= (w_res_nx == '0);
        end
    end

    assign busy       = (r_state == S_RUN);
    assign valid      = r_valid;
    assign alu_result = r_res;
    assign zero       = r_zero;
endmodule
